// File: rtl/regfile_write_arbiter.sv
// Single owner of the register-file write port: zero-fills every register after reset,
// then round-robin arbitrates NREQ writeback requesters onto the one registered write port.
module regfile_write_arbiter #(
  parameter int W     = 32,
  parameter int NREQ  = 2,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0]  req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [W-1:0]       wr_data,
  output logic [IDW-1:0]     grant_id,
  output logic               init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  sweep_cnt;
  logic [IDW-1:0] rr_ptr;

  logic           grant_vld_p0;
  logic [IDW-1:0] grant_idx_p0;
  logic [IDW-1:0] scan_idx_p0;
  logic [AW-1:0]  sel_addr_p0;
  logic [W-1:0]   sel_data_p0;
  logic           sweep_last;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    if (int'(g) == NREQ - 1) return '0;
    else                     return g + IDW'(1);
  endfunction

  assign sweep_last = (sweep_cnt == AW'(NREGS - 1));

  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_last) state_nxt = RUN;
  end

  // Stage p0: combinational round-robin grant, scanning upward from rr_ptr
  always_comb begin
    req_ready    = '0;
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    scan_idx_p0  = '0;
    if (state == RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx_p0 = IDW'((int'(rr_ptr) + k) % NREQ);
        if (!grant_vld_p0 && req_valid[scan_idx_p0]) begin
          grant_vld_p0           = 1'b1;
          grant_idx_p0           = scan_idx_p0;
          req_ready[scan_idx_p0] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr_p0 = req_addr[int'(grant_idx_p0)*AW +: AW];
    sel_data_p0 = req_data[int'(grant_idx_p0)*W +: W];
  end

  // Stage p1: registered write port
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= INIT;
      sweep_cnt <= '0;
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        INIT: begin
          wr_en     <= 1'b1;
          wr_addr   <= sweep_cnt;
          wr_data   <= '0;
          sweep_cnt <= sweep_cnt + AW'(1);
          if (sweep_last) init_done <= 1'b1;
        end
        RUN: begin
          if (grant_vld_p0) begin
            // Register 0 is hardwired zero: the handshake completes but nothing is written.
            wr_en    <= (sel_addr_p0 != '0);
            wr_addr  <= sel_addr_p0;
            wr_data  <= sel_data_p0;
            grant_id <= grant_idx_p0;
            rr_ptr   <= next_ptr(grant_idx_p0);
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter: a 2-requester/32-register instance
// and a 4-requester/8-register instance, each checked against an arbitration model.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NREQ=2, NREGS=32
  logic        rst_a;
  logic [1:0]  va;
  logic [9:0]  aa;
  logic [63:0] da;
  logic [1:0]  rdy_a;
  logic        en_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [0:0]  gid_a;
  logic        done_a;

  // Instance B: NREQ=4, NREGS=8
  logic        rst_b;
  logic [3:0]  vb;
  logic [11:0] ab;
  logic [31:0] db;
  logic [3:0]  rdy_b;
  logic        en_b;
  logic [2:0]  waddr_b;
  logic [7:0]  wdata_b;
  logic [1:0]  gid_b;
  logic        done_b;

  regfile_write_arbiter #(.W(32), .NREQ(2), .NREGS(32), .AW(5), .IDW(1)) dut_a (
    .CLK(clk), .reset(rst_a), .req_valid(va), .req_addr(aa), .req_data(da),
    .req_ready(rdy_a), .wr_en(en_a), .wr_addr(waddr_a), .wr_data(wdata_a),
    .grant_id(gid_a), .init_done(done_a));

  regfile_write_arbiter #(.W(8), .NREQ(4), .NREGS(8), .AW(3), .IDW(2)) dut_b (
    .CLK(clk), .reset(rst_b), .req_valid(vb), .req_addr(ab), .req_data(db),
    .req_ready(rdy_b), .wr_en(en_b), .wr_addr(waddr_b), .wr_data(wdata_b),
    .grant_id(gid_b), .init_done(done_b));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: expected registered outputs and round-robin pointer
  int          ma_ptr, mb_ptr;
  logic        ma_en, mb_en;
  logic [4:0]  ma_addr;
  logic [2:0]  mb_addr;
  logic [31:0] ma_data;
  logic [7:0]  mb_data;
  int          ma_gid, mb_gid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after ptr, circularly; -1 when none
  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic init_a();
    va = 2'b11; aa = 10'h3ff; da = '1;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      check("a_init_en", en_a, 1);
      check("a_init_addr", waddr_a, c);
      check("a_init_data", wdata_a, 0);
      check("a_init_done", done_a, c == 31);
      if (c < 31) check("a_init_ready", rdy_a, 0);
    end
    ma_ptr = 0; ma_addr = 5'd31; ma_data = 0; ma_gid = 0; ma_en = 1'b1;
  endtask

  task automatic init_b();
    vb = 4'hf; ab = '1; db = '1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("b_init_en", en_b, 1);
      check("b_init_addr", waddr_b, c);
      check("b_init_done", done_b, c == 7);
      if (c < 7) check("b_init_ready", rdy_b, 0);
    end
    mb_ptr = 0; mb_addr = 3'd7; mb_data = 0; mb_gid = 0; mb_en = 1'b1;
  endtask

  task automatic run_a(input logic [1:0] v, input logic [9:0] a, input logic [63:0] d);
    int g;
    va = v; aa = a; da = d; #1;
    g = pick({2'b00, v}, ma_ptr, 2);
    check("a_ready", rdy_a, (g < 0) ? 0 : (1 << g));
    @(posedge clk); #1;
    if (g >= 0) begin
      ma_addr = a[g*5 +: 5];
      ma_data = d[g*32 +: 32];
      ma_en   = (ma_addr != 0);
      ma_gid  = g;
      ma_ptr  = (g + 1) % 2;
    end else begin
      ma_en = 1'b0;
    end
    check("a_wr_en", en_a, ma_en);
    check("a_wr_addr", waddr_a, ma_addr);
    check("a_wr_data", wdata_a, ma_data);
    check("a_grant_id", gid_a, ma_gid);
    check("a_init_done", done_a, 1);
  endtask

  task automatic run_b(input logic [3:0] v, input logic [11:0] a, input logic [31:0] d);
    int g;
    vb = v; ab = a; db = d; #1;
    g = pick(v, mb_ptr, 4);
    check("b_ready", rdy_b, (g < 0) ? 0 : (1 << g));
    @(posedge clk); #1;
    if (g >= 0) begin
      mb_addr = a[g*3 +: 3];
      mb_data = d[g*8 +: 8];
      mb_en   = (mb_addr != 0);
      mb_gid  = g;
      mb_ptr  = (g + 1) % 4;
    end else begin
      mb_en = 1'b0;
    end
    check("b_wr_en", en_b, mb_en);
    check("b_wr_addr", waddr_b, mb_addr);
    check("b_wr_data", wdata_b, mb_data);
    check("b_grant_id", gid_b, mb_gid);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    va = '0; aa = '0; da = '0;
    vb = '0; ab = '0; db = '0;

    // Reset state, with requests asserted that must be ignored
    va = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_en", en_a, 0);
    check("a_rst_addr", waddr_a, 0);
    check("a_rst_data", wdata_a, 0);
    check("a_rst_gid", gid_a, 0);
    check("a_rst_done", done_a, 0);
    check("a_rst_ready", rdy_a, 0);

    // Full INIT sweep
    rst_a = 1'b1;
    init_a();

    // Single requester
    run_a(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF});
    check("a_t2_addr", waddr_a, 5);
    check("a_t2_data", wdata_a, 32'hDEADBEEF);

    // Both requesters held: alternating grants, a write every cycle
    for (int i = 0; i < 6; i++)
      run_a(2'b11, {5'd2, 5'd1}, {32'h2222_0000 + i, 32'h1111_0000 + i});

    // Address 0 completes the handshake without writing, then pointer has moved to 0
    run_a(2'b10, {5'd0, 5'd9}, {32'h1234, 32'h0});
    check("a_t4_noen", en_a, 0);
    run_a(2'b11, {5'd4, 5'd3}, {32'h44, 32'h33});
    check("a_t4_gid", gid_a, 0);
    run_a(2'b00, {5'd4, 5'd3}, {32'h44, 32'h33});

    // Random traffic
    for (int i = 0; i < 150; i++)
      run_a(2'($urandom_range(0, 3)), 10'($urandom), {$urandom, $urandom});

    // Reset mid-INIT at address 10 restarts the sweep from 0
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    va = 2'b00;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      check("a_mid_addr", waddr_a, c);
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("a_mid_rst_en", en_a, 0);
    check("a_mid_rst_addr", waddr_a, 0);
    check("a_mid_rst_done", done_a, 0);
    rst_a = 1'b1;
    init_a();
    run_a(2'b10, {5'd6, 5'd0}, {32'hABCD, 32'h0});

    // Reset on a RUN handshake drops the write
    va = 2'b01; aa = {5'd0, 5'd7}; da = {32'h0, 32'h77};
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("a_run_rst_en", en_a, 0);
    check("a_run_rst_addr", waddr_a, 0);
    check("a_run_rst_done", done_a, 0);
    rst_a = 1'b1;
    init_a();
    for (int i = 0; i < 20; i++)
      run_a(2'($urandom_range(0, 3)), 10'($urandom), {$urandom, $urandom});

    // Four requesters: move pointer to 3, then wrap
    rst_b = 1'b1;
    init_b();
    run_b(4'b0100, {3'd0, 3'd6, 3'd0, 3'd0}, {8'h0, 8'h66, 8'h0, 8'h0});
    run_b(4'b0011, {3'd0, 3'd0, 3'd2, 3'd1}, {8'h0, 8'h0, 8'h22, 8'h11});
    check("b_wrap_gid", gid_b, 0);
    run_b(4'b0000, '0, '0);
    check("b_idle_en", en_b, 0);
    run_b(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, {8'h44, 8'h33, 8'h22, 8'h11});
    check("b_after_idle_gid", gid_b, 1);
    for (int i = 0; i < 150; i++)
      run_b(4'($urandom_range(0, 15)), 12'($urandom), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
